// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces press and release, reports row*4+col.
// Optional KEYPAD_AUTOREPEAT_EN re-pulses key_valid every REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_sync,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SD_MAX     = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_CYCLES = (SD_MAX > REPEAT_CYCLES) ? SD_MAX : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [3:0] NO_KEY   = 4'hF;
  localparam logic [3:0] ROW_HOME = 4'b1110;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       col_pat;
  logic [1:0]       key_row;

  logic cnt_clear;
  logic cnt_inc;
  logic row_advance;
  logic row_home;
  logic latch_key;
  logic accept;
  logic repeat_fire;

  function automatic logic single_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  // Columns are only examined on the final cycle of a row dwell so the synchronizer has settled.
  always_comb begin
    next_state  = state;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    row_advance = 1'b0;
    row_home    = 1'b0;
    latch_key   = 1'b0;
    accept      = 1'b0;
    repeat_fire = 1'b0;
    case (state)
      ST_SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_clear = 1'b1;
          if (single_low(cols_sync)) begin
            latch_key  = 1'b1;
            next_state = ST_DEBOUNCE;
          end else begin
            row_advance = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (cols_sync != col_pat) begin
          next_state  = ST_SCAN;
          cnt_clear   = 1'b1;
          row_advance = 1'b1;
        end else if (cnt == DEB_LAST) begin
          accept     = 1'b1;
          cnt_clear  = 1'b1;
          next_state = ST_HELD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_HELD: begin
        if (cols_sync == NO_KEY) begin
          next_state = ST_RELEASE;
          cnt_clear  = 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (cnt == REP_LAST) begin
          repeat_fire = 1'b1;
          cnt_clear   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        if (cols_sync != NO_KEY) begin
          cnt_clear = 1'b1;
        end else if (cnt == DEB_LAST) begin
          next_state = ST_SCAN;
          cnt_clear  = 1'b1;
          row_home   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        next_state = ST_SCAN;
        cnt_clear  = 1'b1;
        row_home   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_SCAN;
    end else begin
      state <= next_state;
    end
  end

  // Shared dwell/debounce/repeat counter; it saturates so a stuck condition can never wrap into a false match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clear) begin
      cnt <= '0;
    end else if (cnt_inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rows <= ROW_HOME;
    end else if (row_home) begin
      rows <= ROW_HOME;
    end else if (row_advance) begin
      rows <= {rows[2:0], rows[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_pat <= NO_KEY;
      key_row <= 2'd0;
    end else if (latch_key) begin
      col_pat <= cols_sync;
      key_row <= low_index(rows);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept | repeat_fire;
      if (accept) begin
        key_code <= {key_row, low_index(col_pat)};
      end
    end
  end

  assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with short timing parameters (scan 4, debounce 8, repeat 16).
// Define KEYPAD_AUTOREPEAT_EN for both bench and RTL to exercise the auto-repeat checks.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols_sync;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;

  typedef struct {
    int         cycles;
    logic [3:0] cols;
    logic [3:0] exp_rows;
    logic       exp_held;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols_sync(cols_sync),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] cols);
    cols_sync = cols;
  endtask

  // Advance one clock and sample on the falling edge; every key_valid pulse is seen exactly once.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply_stimulus(4'hF);
    tick();
    tick();
    reset  = 1'b1;
    pulses = 0;
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    cols_sync = 4'hF;

    vecs[0] = '{3, 4'hF,    4'b1110, 1'b0, 0};
    vecs[1] = '{1, 4'hF,    4'b1101, 1'b0, 0};
    vecs[2] = '{4, 4'hF,    4'b1011, 1'b0, 0};
    vecs[3] = '{4, 4'hF,    4'b0111, 1'b0, 0};
    vecs[4] = '{4, 4'hF,    4'b1110, 1'b0, 0};
    vecs[5] = '{4, 4'b1100, 4'b1101, 1'b0, 0};
    vecs[6] = '{4, 4'b1100, 4'b1011, 1'b0, 0};
    vecs[7] = '{4, 4'b1100, 4'b0111, 1'b0, 0};
    vecs[8] = '{4, 4'b1100, 4'b1110, 1'b0, 0};

    do_reset();
    check_output("reset_rows",  32'(rows),      32'(4'b1110));
    check_output("reset_code",  32'(key_code),  32'd0);
    check_output("reset_valid", 32'(key_valid), 32'd0);
    check_output("reset_held",  32'(key_held),  32'd0);

    // Idle rotation followed by a two-column press that must be ignored.
    for (int i = 0; i < 9; i++) begin
      pulses = 0;
      apply_stimulus(vecs[i].cols);
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      check_output($sformatf("vec%0d_rows", i),   32'(rows),     32'(vecs[i].exp_rows));
      check_output($sformatf("vec%0d_held", i),   32'(key_held), 32'(vecs[i].exp_held));
      check_output($sformatf("vec%0d_pulses", i), 32'(pulses),   32'(vecs[i].exp_pulses));
    end

    // Key at row 2 / column 2: columns only pull low while row 2 is driven.
    do_reset();
    n = 0;
    while (key_held !== 1'b1 && n < 100) begin
      apply_stimulus((rows == 4'b1011) ? 4'b1011 : 4'hF);
      tick();
      n++;
    end
    check_output("press_accepted", 32'(key_held), 32'd1);
    check_output("press_code",     32'(key_code), 32'd10);
    check_output("press_pulse",    32'(pulses),   32'd1);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus((rows == 4'b1011) ? 4'b1011 : 4'hF);
      tick();
    end
    check_output("press_single_pulse", 32'(pulses), 32'd1);
    // One edge for HELD to see the release, then eight clean cycles in RELEASE.
    apply_stimulus(4'hF);
    n = 0;
    while (key_held === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_output("release_cycles",    32'(n),        32'd9);
    check_output("release_rows",      32'(rows),     32'(4'b1110));
    check_output("release_code_kept", 32'(key_code), 32'd10);
    check_output("release_pulses",    32'(pulses),   32'd1);

    // Reset lands on the edge that would accept key 0; it must win with no pulse.
    pulses = 0;
    apply_stimulus(4'b1110);
    for (int c = 0; c < 11; c++) tick();
    check_output("pre_reset_held", 32'(key_held), 32'd0);
    reset = 1'b0;
    tick();
    check_output("midreset_valid",  32'(key_valid), 32'd0);
    check_output("midreset_code",   32'(key_code),  32'd0);
    check_output("midreset_rows",   32'(rows),      32'(4'b1110));
    check_output("midreset_pulses", 32'(pulses),    32'd0);
    reset = 1'b1;
    apply_stimulus(4'hF);

    // Five-cycle glitch on row 0: DEBOUNCE freezes rows, then the drop sends scanning to row 1.
    do_reset();
    apply_stimulus(4'b1110);
    for (int c = 0; c < 5; c++) tick();
    check_output("glitch_rows_frozen", 32'(rows), 32'(4'b1110));
    apply_stimulus(4'hF);
    tick();
    check_output("glitch_rows_next", 32'(rows),     32'(4'b1101));
    check_output("glitch_held",      32'(key_held), 32'd0);
    check_output("glitch_pulses",    32'(pulses),   32'd0);

    // Release bounce at count 5 restarts the release debounce.
    do_reset();
    apply_stimulus(4'b1110);
    n = 0;
    while (key_held !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_output("bounce_accepted", 32'(key_held), 32'd1);
    for (int c = 0; c < 3; c++) tick();
    apply_stimulus(4'hF);
    tick();
    for (int c = 0; c < 5; c++) tick();
    check_output("bounce_held_at5", 32'(key_held), 32'd1);
    apply_stimulus(4'b1110);
    tick();
    apply_stimulus(4'hF);
    for (int c = 0; c < 7; c++) tick();
    check_output("bounce_held_after7", 32'(key_held), 32'd1);
    tick();
    check_output("bounce_released", 32'(key_held), 32'd0);
    check_output("bounce_rows",     32'(rows),     32'(4'b1110));
    check_output("bounce_pulses",   32'(pulses),   32'd1);

    // Long hold of key 0: repeat pulses only when auto-repeat is built in.
    do_reset();
    apply_stimulus(4'b1110);
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_output("hold_first_pulse", 32'(key_valid), 32'd1);
    pulses = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int hits[$];
      for (int k = 1; k <= 60; k++) begin
        tick();
        if (key_valid === 1'b1) begin
          hits.push_back(k);
          check_output($sformatf("repeat_code_%0d", k), 32'(key_code), 32'd0);
        end
      end
      check_output("repeat_count", 32'(hits.size()), 32'd3);
      if (hits.size() == 3) begin
        check_output("repeat_at_16", 32'(hits[0]), 32'd16);
        check_output("repeat_at_32", 32'(hits[1]), 32'd32);
        check_output("repeat_at_48", 32'(hits[2]), 32'd48);
      end
    end
`else
    for (int k = 1; k <= 60; k++) tick();
    check_output("no_repeat_pulses", 32'(pulses),   32'd0);
    check_output("no_repeat_held",   32'(key_held), 32'd1);
    check_output("no_repeat_code",   32'(key_code), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
